led_matrix_frame_scheduler: RTL and testbench

Frame-level scheduler for the LED matrix pixel input path. It shares the matrix write port between two pixel sources: source 0 is the host stream from the ESP32 link, and source 1 is the on-chip pattern/idle generator. It grants one complete frame at a time, and only after the matrix has reported an image boundary. A stalled source is cut off with a timeout, and the rest of its frame is padded with black, so the framebuffer never loses frame alignment.

---
 rtl/led_matrix_frame_scheduler_if.sv | 27 ++
 rtl/led_matrix_frame_scheduler.sv | 119 +++++++++++
 tb/tb_led_matrix_frame_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_matrix_frame_scheduler_if.sv
// Pixel-source and matrix-side signals of the LED matrix frame scheduler.
// The slave modport is the scheduler's view; the master modport is the surrounding fabric.
interface led_matrix_frame_scheduler_if #(
    parameter int unsigned COLOR_DEPTH = 8
);
    logic                         s0_req;
    logic                         s0_valid;
    logic [2:0][COLOR_DEPTH-1:0]  s0_rgb;
    logic                         s0_ready;
    logic                         s1_req;
    logic                         s1_valid;
    logic [2:0][COLOR_DEPTH-1:0]  s1_rgb;
    logic                         s1_ready;
    logic                         pix_valid;
    logic                         pix_sync;
    logic [2:0][COLOR_DEPTH-1:0]  pix_rgb;

    modport slave (
        input  s0_req, s0_valid, s0_rgb, s1_req, s1_valid, s1_rgb,
        output s0_ready, s1_ready, pix_valid, pix_sync, pix_rgb
    );

    modport master (
        output s0_req, s0_valid, s0_rgb, s1_req, s1_valid, s1_rgb,
        input  s0_ready, s1_ready, pix_valid, pix_sync, pix_rgb
    );
endinterface

// File: rtl/led_matrix_frame_scheduler.sv
// Grants the matrix write port to one pixel source a whole frame at a time, gated by image_sync,
// and pads a stalled frame with black so the framebuffer keeps its alignment.
module led_matrix_frame_scheduler #(
    parameter int unsigned PANEL_ROWS  = 32,
    parameter int unsigned PANEL_COLS  = 64,
    parameter int unsigned COLOR_DEPTH = 8,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          image_sync,
    led_matrix_frame_scheduler_if.slave   bus,
    output logic                          active_src,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          timeout_abort
);
    localparam int unsigned FRAME_PIX = PANEL_ROWS * PANEL_COLS;
    localparam int unsigned PIX_W     = $clog2(FRAME_PIX);
    localparam int unsigned STALL_W   = $clog2(TIMEOUT);

    localparam logic [PIX_W-1:0]   PixLast   = PIX_W'(FRAME_PIX - 1);
    localparam logic [PIX_W-1:0]   PixOne    = PIX_W'(1);
    localparam logic [STALL_W-1:0] StallOne  = STALL_W'(1);
    localparam logic [STALL_W-1:0] StallMax  = STALL_W'(TIMEOUT - 1);
    // Trip one count early so PAD is the state exactly TIMEOUT cycles after the last accept.
    localparam logic [STALL_W-1:0] StallTrip = STALL_W'(TIMEOUT - 2);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StXfer = 2'd1;
    localparam logic [1:0] StPad  = 2'd2;

    logic [1:0]                  state;
    logic                        token;
    logic [PIX_W-1:0]            pix_cnt;
    logic [STALL_W-1:0]          stall_cnt;
    logic                        grant;
    logic                        accept;
    logic [2:0][COLOR_DEPTH-1:0] src_rgb;

    assign bus.s0_ready = (state == StXfer) && !active_src;
    assign bus.s1_ready = (state == StXfer) && active_src;

    assign grant   = (state == StIdle) && token && (bus.s0_req || bus.s1_req);
    assign accept  = active_src ? (bus.s1_ready && bus.s1_valid) : (bus.s0_ready && bus.s0_valid);
    assign src_rgb = active_src ? bus.s1_rgb : bus.s0_rgb;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= StIdle;
            token         <= 1'b1;
            active_src    <= 1'b0;
            pix_cnt       <= '0;
            stall_cnt     <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            timeout_abort <= 1'b0;
            bus.pix_valid <= 1'b0;
            bus.pix_sync  <= 1'b0;
            bus.pix_rgb   <= '0;
        end else begin
            bus.pix_valid <= 1'b0;
            bus.pix_sync  <= 1'b0;
            bus.pix_rgb   <= '0;
            frame_done    <= 1'b0;
            timeout_abort <= 1'b0;
            // A boundary arriving with the grant keeps the token set.
            token         <= image_sync || (token && !grant);

            unique case (state)
                StIdle: begin
                    if (grant) begin
                        state      <= StXfer;
                        busy       <= 1'b1;
                        active_src <= !bus.s0_req;
                        pix_cnt    <= '0;
                        stall_cnt  <= '0;
                    end
                end
                StXfer: begin
                    if (accept) begin
                        bus.pix_valid <= 1'b1;
                        bus.pix_sync  <= (pix_cnt == '0);
                        bus.pix_rgb   <= src_rgb;
                        pix_cnt       <= pix_cnt + PixOne;
                        stall_cnt     <= '0;
                        if (pix_cnt == PixLast) begin
                            state      <= StIdle;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end
                    end else begin
                        if (stall_cnt != StallMax) begin
                            stall_cnt <= stall_cnt + StallOne;
                        end
                        if (stall_cnt == StallTrip) begin
                            state         <= StPad;
                            timeout_abort <= 1'b1;
                        end
                    end
                end
                StPad: begin
                    bus.pix_valid <= 1'b1;
                    bus.pix_sync  <= (pix_cnt == '0);
                    pix_cnt       <= pix_cnt + PixOne;
                    if (pix_cnt == PixLast) begin
                        state      <= StIdle;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_led_matrix_frame_scheduler.sv
// Randomized bench: each frame's expected output stream is derived from the source's valid
// pattern using the grant, accept, timeout and pad timing rules.
module tb_led_matrix_frame_scheduler;
    localparam int ROWS    = 4;
    localparam int COLS    = 4;
    localparam int CD      = 8;
    localparam int TIMEOUT = 8;
    localparam int FRAME   = ROWS * COLS;
    localparam int MAXC    = 512;

    typedef logic [2:0][CD-1:0] rgb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic image_sync = 1'b0;
    logic active_src, busy, frame_done, timeout_abort;

    led_matrix_frame_scheduler_if #(.COLOR_DEPTH(CD)) bus ();

    led_matrix_frame_scheduler #(
        .PANEL_ROWS (ROWS),
        .PANEL_COLS (COLS),
        .COLOR_DEPTH(CD),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .image_sync   (image_sync),
        .bus          (bus),
        .active_src   (active_src),
        .busy         (busy),
        .frame_done   (frame_done),
        .timeout_abort(timeout_abort)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit token_m;

    bit   vpat   [MAXC];
    rgb_t rgb_in [MAXC];
    bit   e_valid[MAXC];
    bit   e_sync [MAXC];
    rgb_t e_rgb  [MAXC];
    bit   e_done [MAXC];
    bit   e_abort[MAXC];
    bit   e_busy [MAXC];
    bit   e_rdy  [MAXC];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_quiet();
        bus.s0_req   = 1'b0;
        bus.s1_req   = 1'b0;
        bus.s0_valid = 1'b0;
        bus.s1_valid = 1'b0;
        image_sync   = 1'b0;
    endtask

    // Grants a frame in the current cycle and checks every output up to its frame_done cycle.
    task automatic run_frame(input bit r0, input bit r1, input int sync_c, input string name);
        int last, cnt, done_c, xfer_end, src;
        logic [6:0] obs, exp;
        src = r0 ? 0 : 1;
        for (int c = 0; c < MAXC; c++) begin
            e_valid[c] = 0; e_sync[c] = 0; e_rgb[c] = '0; e_done[c] = 0;
            e_abort[c] = 0; e_busy[c] = 0; e_rdy[c] = 0;
            rgb_in[c]  = 24'($urandom);
        end
        last = 0; cnt = 0; done_c = -1; xfer_end = 0;
        for (int c = 1; c < MAXC - FRAME - 2 && done_c < 0; c++) begin
            if (c == last + TIMEOUT) begin
                e_abort[c] = 1;
                xfer_end   = c - 1;
                for (int k = 0; k < FRAME - cnt; k++) begin
                    e_valid[c + 1 + k] = 1;
                    e_sync[c + 1 + k]  = (cnt + k == 0);
                end
                done_c = c + FRAME - cnt;
            end else if (vpat[c]) begin
                e_valid[c + 1] = 1;
                e_sync[c + 1]  = (cnt == 0);
                e_rgb[c + 1]   = rgb_in[c];
                cnt++;
                last = c;
                if (cnt == FRAME) begin
                    done_c   = c + 1;
                    xfer_end = c;
                end
            end
        end
        if (done_c < 0) begin
            bad++;
            $display("FAIL %s model: frame end not found within %0d cycles", name, MAXC);
            return;
        end
        e_done[done_c] = 1;
        for (int c = 1; c < done_c; c++) e_busy[c] = 1;
        for (int c = 1; c <= xfer_end; c++) e_rdy[c] = 1;

        for (int c = 0; c < done_c; c++) begin
            if (c == 0) begin
                bus.s0_req = r0;
                bus.s1_req = r1;
            end else if (c == done_c - 1) begin
                bus.s0_req = 1'b0;
                bus.s1_req = 1'b0;
            end else begin
                bus.s0_req = 1'($urandom_range(0, 1));
                bus.s1_req = 1'($urandom_range(0, 1));
            end
            image_sync = (c == sync_c);
            if (src == 0) begin
                bus.s0_valid = vpat[c];
                bus.s0_rgb   = rgb_in[c];
                bus.s1_valid = 1'($urandom_range(0, 1));
                bus.s1_rgb   = 24'($urandom);
            end else begin
                bus.s1_valid = vpat[c];
                bus.s1_rgb   = rgb_in[c];
                bus.s0_valid = 1'($urandom_range(0, 1));
                bus.s0_rgb   = 24'($urandom);
            end
            step();
            begin
                int n = c + 1;
                obs = {bus.pix_valid, bus.pix_sync, frame_done, timeout_abort, busy,
                       bus.s0_ready, bus.s1_ready};
                exp = {e_valid[n], e_sync[n], e_done[n], e_abort[n], e_busy[n],
                       e_rdy[n] && (src == 0), e_rdy[n] && (src == 1)};
                total++;
                if (obs !== exp) begin
                    bad++;
                    $display("FAIL %s ctrl cyc %0d {valid,sync,done,abort,busy,rdy0,rdy1} got %b want %b",
                             name, n, obs, exp);
                end
                if (e_valid[n]) begin
                    total++;
                    if (bus.pix_rgb !== e_rgb[n]) begin
                        bad++;
                        $display("FAIL %s rgb cyc %0d got %h want %h", name, n, bus.pix_rgb, e_rgb[n]);
                    end
                end
                if (e_busy[n]) begin
                    total++;
                    if (active_src !== 1'(src)) begin
                        bad++;
                        $display("FAIL %s active_src cyc %0d got %b want %0d", name, n, active_src, src);
                    end
                end
            end
        end
        token_m = (sync_c >= 0 && sync_c < done_c);
    endtask

    task automatic idle(input int n, input bit sync_first);
        for (int i = 0; i < n; i++) begin
            drive_quiet();
            image_sync = sync_first && (i == 0);
            step();
            total++;
            if (busy !== 1'b0 || bus.pix_valid !== 1'b0) begin
                bad++;
                $display("FAIL idle busy/pix_valid got %b%b want 00", busy, bus.pix_valid);
            end
        end
        if (sync_first && n > 0) token_m = 1;
        image_sync = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        logic [31:0] v;
        v = {bus.pix_valid, bus.pix_sync, bus.pix_rgb, bus.s0_ready, bus.s1_ready, busy,
             frame_done, timeout_abort, active_src};
        total++;
        if (v !== '0) begin
            bad++;
            $display("FAIL %s outputs got %h want 0", name, v);
        end
    endtask

    task automatic test_reset();
        drive_quiet();
        bus.s0_rgb = '0;
        bus.s1_rgb = '0;
        rst = 1'b1;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        token_m = 1;
    endtask

    task automatic test_steady();
        for (int c = 0; c < MAXC; c++) vpat[c] = 1;
        run_frame(1, 0, -1, "steady");
    endtask

    task automatic test_no_regrant();
        bus.s0_req   = 1'b1;
        bus.s0_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if (busy !== 1'b0 || bus.s0_ready !== 1'b0 || bus.pix_valid !== 1'b0) begin
                bad++;
                $display("FAIL no_regrant busy/rdy/valid got %b%b%b want 000",
                         busy, bus.s0_ready, bus.pix_valid);
            end
        end
        drive_quiet();
    endtask

    task automatic test_priority();
        for (int c = 0; c < MAXC; c++) vpat[c] = 1;
        idle(2, 1);
        run_frame(1, 1, -1, "prio_both");
        idle(2, 1);
        run_frame(0, 1, -1, "prio_s1");
    endtask

    task automatic test_timeout();
        for (int c = 0; c < MAXC; c++) vpat[c] = (c >= 1 && c <= 5);
        idle(2, 1);
        run_frame(1, 0, -1, "timeout");
    endtask

    task automatic test_gapped();
        for (int c = 0; c < MAXC; c++) vpat[c] = (c >= 1) && ((c - 1) % 7 == 0);
        idle(2, 1);
        run_frame(1, 0, -1, "gapped");
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < MAXC; c++) vpat[c] = 1;
        idle(2, 1);
        run_frame(1, 0, 0, "collision_first");
        total++;
        if (token_m !== 1'b1) begin
            bad++;
            $display("FAIL collision token model got %b want 1", token_m);
        end
        run_frame(0, 1, -1, "collision_second");
    endtask

    task automatic test_reset_mid();
        idle(2, 1);
        bus.s0_req   = 1'b1;
        bus.s0_valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            bus.s0_rgb = 24'($urandom);
            step();
        end
        total++;
        if (bus.pix_valid !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid pre valid/busy got %b%b want 11", bus.pix_valid, busy);
        end
        rst = 1'b1;
        step();
        check_all_zero("reset_mid");
        rst = 1'b0;
        drive_quiet();
        token_m = 1;
        for (int c = 0; c < MAXC; c++) vpat[c] = 1;
        run_frame(1, 0, -1, "after_reset");
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int c;
            bit r0, r1;
            for (int k = 0; k < MAXC; k++) vpat[k] = 0;
            c = 1 + $urandom_range(0, 3);
            while (c < MAXC) begin
                int gap;
                vpat[c] = 1;
                gap = ($urandom_range(0, 5) == 0) ? $urandom_range(5, 9) : $urandom_range(0, 3);
                c += gap + 1;
            end
            r0 = 1'($urandom_range(0, 1));
            r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
            idle(1 + $urandom_range(0, 3), 1);
            run_frame(r0, r1, $urandom_range(0, 1) ? $urandom_range(0, 20) : -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_no_regrant();
        test_priority();
        test_timeout();
        test_gapped();
        test_back_to_back();
        test_reset_mid();
        test_random();
        idle(3, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
